// File: rtl/fetch_stage.sv
// fetch_stage -- rv32 instruction fetch stage.
// Owns the PC and issues word requests to instruction memory. Responses arrive
// in order and are buffered. The buffered {instr, pc} pairs go to decode over a
// valid/ready handshake. A redirect reloads the PC, flushes the buffer and
// discards responses that are still in flight.
//
// Parameters: RESET_PC (word aligned), BUF_DEPTH (power of 2, >= 2)
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_req_valid/ready/addr       fetch request channel
//   imem_rsp_valid/data             in-order response words, latency >= 1
//   redirect_valid/pc               taken branch/jump/trap (pc[1:0] ignored)
//   id_valid/ready/instr/pc         buffer head toward decode
//   perf_fetch_cnt                  decode handshake count (FETCH_PERF_EN only)
// Optional feature macro: FETCH_PERF_EN
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_RST,
    ST_FETCH,
    ST_FLUSH
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        buf_instr_q [BUF_DEPTH];
  logic [31:0]        buf_pc_q    [BUF_DEPTH];

  logic [CNT_W:0]     inflight;
  logic               req_fire;
  logic               push;
  logic               pop;
  logic [31:0]        redirect_pc_al;
  logic               unused_redirect_lsb;

  assign redirect_pc_al      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit rule: buffered words plus requests in flight never exceed the
  // buffer depth, so every accepted response always has a free slot.
  assign inflight       = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = (state_q != ST_RST) && !redirect_valid &&
                          (inflight < {1'b0, DEPTH_C});
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign id_valid = (count_q != '0);
  assign id_instr = buf_instr_q[rd_ptr_q];
  assign id_pc    = buf_pc_q[rd_ptr_q];

  // A redirect cancels both the push of a same-cycle response and any pop.
  assign push = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign pop  = id_valid && id_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    state_d    = state_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc_al;
      rsp_pc_d   = redirect_pc_al;
      outst_d    = outst_q - CNT_W'(imem_rsp_valid);
      // Whatever is still in flight after this cycle belongs to the old path.
      drop_cnt_d = outst_q - CNT_W'(imem_rsp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // FETCH/FLUSH both collapse to one rule on the updated drop count.
    unique case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH,
      ST_FLUSH: state_d = (drop_cnt_d != '0) ? ST_FLUSH : ST_FETCH;
      default:  state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RST;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        buf_instr_q[wr_ptr_q] <= imem_rsp_data;
        buf_pc_q[wr_ptr_q]    <= rsp_pc_q;
      end
      assert (!(push && !pop && (count_q == DEPTH_C)));
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)      perf_cnt_q <= '0;
    else if (pop) perf_cnt_q <= perf_cnt_q + 32'd1;
  end

  assign perf_fetch_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- directed self-checking bench for fetch_stage.
// A small in-order instruction memory model answers requests with a fixed
// word pattern derived from the address; decode handshakes are logged and
// compared against hand-computed PC/instruction sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        rsp_en;
  logic [31:0] pend[$];
  logic [31:0] req_log[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_instr[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pc_at(input int i);
    if (i < log_pc.size()) return log_pc[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] instr_at(input int i);
    if (i < log_instr.size()) return log_instr[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] req_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic present_rsp();
    if (!rst && rsp_en && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // One clock cycle: called at a negedge with inputs already set.
  task automatic step();
    logic        fire;
    logic [31:0] fire_addr;
    logic        rsp_now;
    #1;
    fire      = !rst && imem_req_valid && imem_req_ready;
    fire_addr = imem_req_addr;
    rsp_now   = imem_rsp_valid;
    if (!rst && id_valid && id_ready && !redirect_valid) begin
      log_pc.push_back(id_pc);
      log_instr.push_back(id_instr);
    end
    @(posedge clk);
    if (rsp_now && pend.size() > 0) void'(pend.pop_front());
    if (fire) begin
      pend.push_back(fire_addr);
      req_log.push_back(fire_addr);
    end
    @(negedge clk);
    present_rsp();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_logs();
    log_pc.delete();
    log_instr.delete();
    req_log.delete();
  endtask

  // Reset the DUT together with the memory model, then check reset outputs.
  task automatic do_reset(input string tag);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    steps(2);
    pend.delete();
    clear_logs();
    rst = 1'b0;
    present_rsp();
    #1;
    chk({tag, "_rst_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_rst_req_addr"}, imem_req_addr, 32'h0000_0000);
    chk({tag, "_rst_id_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_rst_id_instr"}, id_instr, 32'h0);
    chk({tag, "_rst_id_pc"}, id_pc, 32'h0);
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    rsp_en         = 1'b1;
    @(negedge clk);

    // 1: streaming fetch from reset
    id_ready = 1'b1;
    rsp_en   = 1'b1;
    do_reset("t1");
    step();
    chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_first_req_addr", imem_req_addr, 32'h0);
    steps(8);
    for (int i = 0; i < 3; i++) begin
      chk("t1_seq_pc", pc_at(i), 32'(4 * i));
      chk("t1_seq_instr", instr_at(i), mem_word(32'(4 * i)));
    end

    // 2: decode stalled, credits exhausted
    id_ready = 1'b0;
    do_reset("t2");
    steps(5);
    chk("t2_req_count", 32'(req_log.size()), 32'd2);
    chk("t2_req_blocked", 32'(imem_req_valid), 32'd0);
    chk("t2_id_valid", 32'(id_valid), 32'd1);
    chk("t2_id_pc", id_pc, 32'h0);
    chk("t2_id_instr", id_instr, mem_word(32'h0));
    steps(3);
    chk("t2_stable_pc", id_pc, 32'h0);
    chk("t2_stable_instr", id_instr, mem_word(32'h0));
    chk("t2_still_blocked", 32'(req_log.size()), 32'd2);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk("t2_req_after_pop", 32'(imem_req_valid), 32'd1);
    chk("t2_addr_after_pop", imem_req_addr, 32'h8);
    chk("t2_head_after_pop", id_pc, 32'h4);

    // 3: redirect with two fetches outstanding
    id_ready = 1'b1;
    rsp_en   = 1'b0;
    do_reset("t3");
    steps(3);
    chk("t3_outstanding_block", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    log_pc.delete();
    log_instr.delete();
    step();
    redirect_valid = 1'b0;
    rsp_en         = 1'b1;
    present_rsp();
    #1;
    chk("t3_req_addr", imem_req_addr, 32'h100);
    steps(8);
    chk("t3_req_after_redirect", req_at(2), 32'h100);
    chk("t3_first_pc", pc_at(0), 32'h100);
    chk("t3_first_instr", instr_at(0), mem_word(32'h100));
    chk("t3_second_pc", pc_at(1), 32'h104);

    // 4: redirect coincides with a response and a pending pop
    id_ready = 1'b1;
    rsp_en   = 1'b1;
    do_reset("t4");
    steps(3);
    chk("t4_pre_id_valid", 32'(id_valid), 32'd1);
    chk("t4_pre_id_pc", id_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4_id_valid_dropped", 32'(id_valid), 32'd0);
    chk("t4_no_pop_logged", 32'(log_pc.size()), 32'd0);
    steps(8);
    chk("t4_first_pc", pc_at(0), 32'h40);
    chk("t4_first_instr", instr_at(0), mem_word(32'h40));
    chk("t4_second_pc", pc_at(1), 32'h44);

    // 5: back-to-back redirects, last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    clear_logs();
    step();
    redirect_pc = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    steps(10);
    chk("t5_first_req", req_at(0), 32'h300);
    chk("t5_first_pc", pc_at(0), 32'h300);
    chk("t5_first_instr", instr_at(0), mem_word(32'h300));
    begin
      int unsigned bad = 0;
      foreach (log_pc[i]) if (log_pc[i][31:8] == 24'h2) bad++;
      chk("t5_no_0x200_words", bad, 32'd0);
    end

    // PC wrap at the top of the address space, with unaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFB;
    clear_logs();
    step();
    redirect_valid = 1'b0;
    steps(12);
    chk("wrap_pc0", pc_at(0), 32'hFFFF_FFF8);
    chk("wrap_pc1", pc_at(1), 32'hFFFF_FFFC);
    chk("wrap_pc2", pc_at(2), 32'h0000_0000);
    chk("wrap_instr2", instr_at(2), mem_word(32'h0));

`ifdef FETCH_PERF_EN
    // 6: performance counter
    id_ready = 1'b1;
    do_reset("t6");
    chk("t6_perf_reset", perf_fetch_cnt, 32'd0);
    for (int i = 0; i < 200 && log_pc.size() < 10; i++) step();
    id_ready = 1'b0;
    chk("t6_reach10", 32'(log_pc.size()), 32'd10);
    chk("t6_perf10", perf_fetch_cnt, 32'd10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0800;
    step();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    for (int i = 0; i < 200 && log_pc.size() < 15; i++) step();
    id_ready = 1'b0;
    chk("t6_reach15", 32'(log_pc.size()), 32'd15);
    chk("t6_perf15", perf_fetch_cnt, 32'd15);
    force dut.perf_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_cnt_q;
    id_ready = 1'b1;
    for (int i = 0; i < 200 && log_pc.size() < 16; i++) step();
    id_ready = 1'b0;
    chk("t6_reach16", 32'(log_pc.size()), 32'd16);
    chk("t6_perf_wrap", perf_fetch_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
